// File: rtl/mem_arbiter_if.sv
// Request/ack and memory-port bundle shared by the fetch path, the data path and the arbiter.
// The requester/memory side uses the master view and the arbiter uses the slave view.
interface mem_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        owner;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data; data wins unless fetch has starved.
// Grant -> MEM_LAT BUSY cycles -> one RESP cycle with ack; requests are only sampled in IDLE.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_grant;
    logic        w_grant_d;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_owner;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;

    always_comb begin
        w_state_nxt = S_IDLE;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data keeps priority only while fetch has not been passed over STARVE_MAX times.
                if (bus.d_req && (!bus.if_req || (r_starve_cnt < STARVE_LIM))) begin
                    w_grant     = 1'b1;
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (bus.if_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY:  w_state_nxt = (r_lat_cnt == 4'd0) ? S_RESP : S_BUSY;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner   <= w_grant_d;
                r_we      <= w_grant_d & bus.d_we;
                r_addr    <= w_grant_d ? bus.d_addr : bus.if_addr;
                r_wdata   <= w_grant_d ? bus.d_wdata : '0;
                r_lat_cnt <= LAT_INIT;
                if (!w_grant_d) begin
                    r_starve_cnt <= 4'd0;
                end else if (bus.if_req && (r_starve_cnt != 4'hF)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
            if (r_state == S_BUSY) begin
                if (r_lat_cnt != 4'd0) begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end else if (!r_we) begin
                    r_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = (r_state == S_BUSY);
    assign bus.mem_we    = (r_state == S_BUSY) & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rdata     = r_rdata;
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state == S_BUSY) || (r_state == S_RESP);
    assign bus.if_ack    = (r_state == S_RESP) & ~r_owner;
    assign bus.d_ack     = (r_state == S_RESP) & r_owner;
endmodule
